// File: rtl/irq_router_pkg.sv
// Shared types and helpers for the interrupt ring router.
package irq_router_pkg;

  typedef logic [31:0] irq_t;

  localparam int unsigned GAP_W = 4;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/irq_fifo.sv
// Per-destination event FIFO. Pointers carry one extra wrap bit so that
// full and empty can be told apart without a separate counter.
module irq_fifo
  import irq_router_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  irq_t wdata,
  input  logic pop,
  output irq_t rdata,
  output logic full,
  output logic empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  irq_t        mem [DEPTH];
  logic        do_push;
  logic        do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  // A pop on the same edge frees the slot, so a push into a full FIFO still lands.
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr[AW-1:0]];

  // Storage write; contents need no reset because the pointers gate every read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  // Pointer advance on accepted push and pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/irq_ring_router.sv
// Routes each CPU's interrupt word to the next CPU in the ring, buffering
// every source change and pacing delivery so each one is observable.
module irq_ring_router
  import irq_router_pkg::*;
#(
  parameter int unsigned N_CPU      = 4,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned MIN_GAP    = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_CPU-1:0][31:0] i_cpu_irq,
  input  logic [N_CPU-1:0]       i_cpu_finish,
  output logic [N_CPU-1:0][31:0] o_cpu_irq,
  output logic                   o_all_finish,
  output logic [N_CPU-1:0]       o_drop,
  output logic [31:0]            o_drop_total
);

  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(MIN_GAP - 1);

  logic [N_CPU-1:0][31:0]      prev;
  logic [N_CPU-1:0][GAP_W-1:0] gap;
  logic [N_CPU-1:0]            push;
  logic [N_CPU-1:0]            pop;
  logic [N_CPU-1:0]            full;
  logic [N_CPU-1:0]            empty;
  logic [N_CPU-1:0]            drop;
  irq_t                        rdata [N_CPU];
  logic [31:0]                 drop_total_next;

  for (genvar d = 0; d < N_CPU; d++) begin : g_dst
    localparam int unsigned SRC = (d + N_CPU - 1) % N_CPU;

    assign push[d] = (i_cpu_irq[SRC] != prev[SRC]);
    assign pop[d]  = !empty[d] && (gap[d] == '0);
    assign drop[d] = push[d] && full[d] && !pop[d];

    irq_fifo #(
      .DEPTH(FIFO_DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push[d]),
      .wdata (i_cpu_irq[SRC]),
      .pop   (pop[d]),
      .rdata (rdata[d]),
      .full  (full[d]),
      .empty (empty[d])
    );
  end

  // Last sampled source values, used to detect changes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev <= '0;
    else        prev <= i_cpu_irq;
  end

  // Delivery: pop the head onto the output and restart the spacing counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_cpu_irq <= '0;
      gap       <= '0;
    end else begin
      for (int unsigned d = 0; d < N_CPU; d++) begin
        if (pop[d]) begin
          o_cpu_irq[d] <= rdata[d];
          gap[d]       <= GAP_LOAD;
        end else if (gap[d] != '0) begin
          gap[d] <= gap[d] - GAP_W'(1);
        end
      end
    end
  end

  // Several destinations can drop on one edge; each adds one, saturating.
  always_comb begin
    drop_total_next = o_drop_total;
    for (int unsigned d = 0; d < N_CPU; d++) begin
      if (drop[d]) drop_total_next = sat_inc(drop_total_next);
    end
  end

  // Sticky drop flags, drop counter and registered finish aggregate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_drop       <= '0;
      o_drop_total <= '0;
      o_all_finish <= 1'b0;
    end else begin
      o_drop       <= o_drop | drop;
      o_drop_total <= drop_total_next;
      o_all_finish <= &i_cpu_finish;
    end
  end

endmodule

// File: tb/tb_irq_ring_router.sv
// Bench for irq_ring_router: three instances with different pacing/depth.
module tb_irq_ring_router;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_chk;
  int   n_fail;

  // Instance A: defaults (depth 8, gap 1)
  logic [3:0][31:0] a_irq, a_out;
  logic [3:0]       a_fin, a_drop;
  logic             a_allf;
  logic [31:0]      a_tot;
  // Instance B: depth 4, gap 3
  logic [3:0][31:0] b_irq, b_out;
  logic [3:0]       b_fin, b_drop;
  logic             b_allf;
  logic [31:0]      b_tot;
  // Instance C: depth 2, gap 15
  logic [3:0][31:0] c_irq, c_out;
  logic [3:0]       c_fin, c_drop;
  logic             c_allf;
  logic [31:0]      c_tot;

  irq_ring_router #(.N_CPU(4), .FIFO_DEPTH(8), .MIN_GAP(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .i_cpu_irq(a_irq), .i_cpu_finish(a_fin),
    .o_cpu_irq(a_out), .o_all_finish(a_allf), .o_drop(a_drop), .o_drop_total(a_tot));

  irq_ring_router #(.N_CPU(4), .FIFO_DEPTH(4), .MIN_GAP(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .i_cpu_irq(b_irq), .i_cpu_finish(b_fin),
    .o_cpu_irq(b_out), .o_all_finish(b_allf), .o_drop(b_drop), .o_drop_total(b_tot));

  irq_ring_router #(.N_CPU(4), .FIFO_DEPTH(2), .MIN_GAP(15)) dut_c (
    .clk(clk), .rst_n(rst_n), .i_cpu_irq(c_irq), .i_cpu_finish(c_fin),
    .o_cpu_irq(c_out), .o_all_finish(c_allf), .o_drop(c_drop), .o_drop_total(c_tot));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard for instance A: per destination, expected value and edge.
  typedef struct {
    logic [31:0] val;
    int          edge_no;
  } exp_t;

  exp_t             exp_q [4][$];
  logic [3:0][31:0] a_snap;
  exp_t             mon_e;

  task automatic a_drive(input int s, input logic [31:0] v);
    exp_t e;
    if (v != a_irq[s]) begin
      e.val     = v;
      e.edge_no = cyc + 2;
      exp_q[(s + 1) % 4].push_back(e);
    end
    a_irq[s] = v;
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      a_snap = a_out;
    end else begin
      for (int d = 0; d < 4; d++) begin
        if (a_out[d] != a_snap[d]) begin
          if (exp_q[d].size() == 0) begin
            check("a_unexpected_change", a_out[d], a_snap[d]);
          end else begin
            mon_e = exp_q[d].pop_front();
            check("a_value", a_out[d], mon_e.val);
            check("a_edge", cyc, mon_e.edge_no);
          end
        end
      end
      a_snap = a_out;
    end
  end

  typedef struct {
    int          src;
    logic [31:0] val;
    int          idle;
  } vec_t;

  vec_t vec [10];

  function automatic logic [31:0] b_model(input int k);
    if (k < 1)        return 32'd0;
    else if (k >= 10) return 32'd4;
    else              return 32'((k - 1) / 3 + 1);
  endfunction

  initial begin
    int r;
    vec[0] = '{3, 32'hDEAD_BEEF, 2};
    vec[1] = '{1, 32'h0000_0001, 0};
    vec[2] = '{1, 32'h0000_0002, 0};
    vec[3] = '{1, 32'h0000_0003, 0};
    vec[4] = '{1, 32'h0000_0004, 2};
    vec[5] = '{2, 32'hA5A5_A5A5, 0};
    vec[6] = '{0, 32'h0000_0000, 0};
    vec[7] = '{0, 32'hFFFF_FFFF, 0};
    vec[8] = '{3, 32'h0000_0000, 1};
    vec[9] = '{2, 32'h5A5A_5A5A, 3};

    clk = 0; cyc = 0; n_chk = 0; n_fail = 0;
    a_irq = '0; b_irq = '0; c_irq = '0;
    a_fin = '0; b_fin = '0; c_fin = '0;
    rst_n = 1;
    #1 rst_n = 0;

    // Reset state
    @(negedge clk);
    for (int d = 0; d < 4; d++) begin
      check("rst_a_out", a_out[d], 32'd0);
      check("rst_c_out", c_out[d], 32'd0);
    end
    check("rst_allf", {31'd0, a_allf}, 32'd0);
    check("rst_drop", {28'd0, a_drop}, 32'd0);
    check("rst_tot", a_tot, 32'd0);
    @(negedge clk);
    rst_n = 1;

    // Single event: driven before edge 5, visible after edge 6
    repeat (2) @(negedge clk);
    a_drive(0, 32'h1234_5678);
    repeat (2) @(negedge clk);
    check("single_dst1", a_out[1], 32'h1234_5678);
    check("single_dst0", a_out[0], 32'd0);
    check("single_dst2", a_out[2], 32'd0);
    check("single_dst3", a_out[3], 32'd0);

    // Table-driven routing, ring wrap and bursts on instance A
    @(negedge clk);
    foreach (vec[i]) begin
      a_drive(vec[i].src, vec[i].val);
      repeat (vec[i].idle + 1) @(negedge clk);
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 4; d++) check("a_queue_drained", exp_q[d].size(), 32'd0);
    check("a_no_drop", {28'd0, a_drop}, 32'd0);
    check("a_tot_zero", a_tot, 32'd0);

    // Finish aggregation
    for (int i = 0; i < 4; i++) begin
      a_fin[i] = 1'b1;
      check("fin_before_edge", {31'd0, a_allf}, 32'd0);
      @(negedge clk);
      check("fin_after_edge", {31'd0, a_allf}, (i == 3) ? 32'd1 : 32'd0);
    end
    a_fin[2] = 1'b0;
    check("fin_hold", {31'd0, a_allf}, 32'd1);
    @(negedge clk);
    check("fin_clear", {31'd0, a_allf}, 32'd0);

    // Overflow on instance C: source 0 -> destination 1
    for (int j = 1; j <= 6; j++) begin
      c_irq[0] = 32'(j);
      @(negedge clk);
      check("ovf_out", c_out[1], (j >= 2) ? 32'd1 : 32'd0);
      check("ovf_tot", c_tot, (j >= 4) ? 32'(j - 3) : 32'd0);
      check("ovf_flag", {31'd0, c_drop[1]}, (j >= 4) ? 32'd1 : 32'd0);
    end
    repeat (10) @(negedge clk);
    check("ovf_wait", c_out[1], 32'd1);
    c_irq[0] = 32'd7;            // arrives on the edge that pops while full
    @(negedge clk);
    check("ovf_pop2", c_out[1], 32'd2);
    check("ovf_full_pushpop_tot", c_tot, 32'd3);
    repeat (14) @(negedge clk);
    check("ovf_hold2", c_out[1], 32'd2);
    @(negedge clk);
    check("ovf_pop3", c_out[1], 32'd3);
    repeat (14) @(negedge clk);
    check("ovf_hold3", c_out[1], 32'd3);
    @(negedge clk);
    check("ovf_pop7", c_out[1], 32'd7);
    check("ovf_final_tot", c_tot, 32'd3);
    check("ovf_other_flags", {29'd0, c_drop[3:2], c_drop[0]}, 32'd0);

    // Gap and order on instance B: source 1 -> destination 2, gap 3
    b_irq[1] = 32'd1;
    for (int k = 0; k <= 12; k++) begin
      @(negedge clk);
      check("gap_out", b_out[2], b_model(k));
      if (k < 3) b_irq[1] = 32'(k + 2);
    end
    check("gap_no_drop", b_tot, 32'd0);
    check("gap_no_flag", {28'd0, b_drop}, 32'd0);

    // Reset mid-operation with three events buffered in B
    b_irq[1] = 32'd5;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      b_irq[1] = 32'(k + 6);
    end
    @(negedge clk);
    check("mid_before_rst", b_out[2], 32'd5);
    for (int d = 0; d < 4; d++) begin
      check("mid_a_queue_empty", exp_q[d].size(), 32'd0);
      exp_q[d].delete();
    end
    b_irq = '0;
    #2 rst_n = 0;
    #1;
    for (int d = 0; d < 4; d++) begin
      check("mid_rst_a_out", a_out[d], 32'd0);
      check("mid_rst_b_out", b_out[d], 32'd0);
      check("mid_rst_c_out", c_out[d], 32'd0);
    end
    check("mid_rst_c_tot", c_tot, 32'd0);
    check("mid_rst_c_flag", {28'd0, c_drop}, 32'd0);
    repeat (2) @(negedge clk);
    r = cyc;
    rst_n = 1;
    // Nonzero sources of A are recaptured on the first edge after release
    for (int d = 0; d < 4; d++) begin
      if (a_irq[(d + 3) % 4] != 32'd0) begin
        exp_t e;
        e.val     = a_irq[(d + 3) % 4];
        e.edge_no = r + 2;
        exp_q[d].push_back(e);
      end
    end
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("mid_b_empty", b_out[2], 32'd0);
    end
    b_irq[1] = 32'h0000_0009;
    @(negedge clk);
    check("mid_b_new_lat", b_out[2], 32'd0);
    @(negedge clk);
    check("mid_b_new", b_out[2], 32'h0000_0009);
    check("mid_b_tot", b_tot, 32'd0);
    check("mid_c_tot_after", c_tot, 32'd0);
    for (int d = 0; d < 4; d++) check("end_a_queue_drained", exp_q[d].size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
